// File: rtl/instr_fetcher.sv
// instr_fetcher: fetch stage that requests one instruction at a time from the icache, hands it to the decoder and follows predicted/redirect PCs
module instr_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_valid,
    input  logic [31:0] icache_data,
    output logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_addr_out,
    output logic        is_compressed,
    input  logic        updating_instr_issued,
    input  logic        instr_issued,
    input  logic [31:0] predict_pc,
    input  logic        rob_clear,
    input  logic [31:0] rob_new_pc
);

    typedef enum logic [1:0] {
        FETCH,
        PRESENT,
        WAIT_PC,
        DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        ready_q, ready_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] iaddr_q, iaddr_d;
    logic        comp_q, comp_d;

    assign icache_req     = req_q;
    assign icache_addr    = addr_q;
    assign instr_ready    = ready_q;
    assign instr_out      = instr_q;
    assign instr_addr_out = iaddr_q;
    assign is_compressed  = comp_q;

    // next-state logic; a flush always overrides acceptance, issue and response handling
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        ready_d = ready_q;
        instr_d = instr_q;
        iaddr_d = iaddr_q;
        comp_d  = comp_q;
        unique case (state_q)
            FETCH: begin
                req_d  = 1'b1;
                addr_d = req_q ? addr_q : pc_q;
                if (rob_clear) begin
                    pc_d    = rob_new_pc;
                    ready_d = 1'b0;
                    if (req_q && !icache_valid) begin
                        state_d = DRAIN;
                    end else begin
                        addr_d = rob_new_pc;
                    end
                end else if (req_q && icache_valid) begin
                    instr_d = icache_data;
                    iaddr_d = pc_q;
                    comp_d  = icache_data[1:0] != 2'b11;
                    req_d   = 1'b0;
                    ready_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (rob_clear) begin
                    pc_d    = rob_new_pc;
                    ready_d = 1'b0;
                    req_d   = 1'b1;
                    addr_d  = rob_new_pc;
                    state_d = FETCH;
                end else if (updating_instr_issued) begin
                    ready_d = 1'b0;
                    state_d = WAIT_PC;
                end
            end
            WAIT_PC: begin
                if (rob_clear) begin
                    pc_d    = rob_new_pc;
                    ready_d = 1'b0;
                    req_d   = 1'b1;
                    addr_d  = rob_new_pc;
                    state_d = FETCH;
                end else if (instr_issued) begin
                    pc_d    = predict_pc;
                    req_d   = 1'b1;
                    addr_d  = predict_pc;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                pc_d = rob_clear ? rob_new_pc : pc_q;
                if (icache_valid) begin
                    addr_d  = rob_clear ? rob_new_pc : pc_q;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // state register; rdy low freezes everything except reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= 32'h0;
            ready_q <= 1'b0;
            instr_q <= 32'h0;
            iaddr_q <= 32'h0;
            comp_q  <= 1'b0;
        end else if (rdy) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
            instr_q <= instr_d;
            iaddr_q <= iaddr_d;
            comp_q  <= comp_d;
        end
    end

endmodule
